acc_ctrl: RTL

ACC_CTRL -- requirements
Module: acc_ctrl

---
 rtl/acc_ctrl_pkg.sv | 16 +
 rtl/acc_ctrl_cnt.sv | 35 +++
 rtl/acc_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/acc_ctrl_pkg.sv
// Shared definitions for the accumulator controller: parameter defaults
// and the controller state encoding.
package acc_ctrl_pkg;

    localparam int DATA_W_DEF = 5;
    localparam int LEN_W_DEF  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/acc_ctrl_cnt.sv
// Operand counter for one accumulation job. Cleared when a job is accepted,
// advanced on every operand transfer. tc flags that the next transfer is the
// last one of the job (count == len-1).
module acc_ctrl_cnt
    import acc_ctrl_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             pclk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [LEN_W-1:0] len,
    output logic             tc
);

    logic [LEN_W-1:0] count_r;

    // Operand count register: cleared at job start, incremented per transfer.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (inc) begin
            count_r <= count_r + LEN_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Compare in LEN_W+1 bits so count+1 never wraps onto a small len.
    assign tc = (({1'b0, count_r} + (LEN_W + 1)'(1)) == {1'b0, len});

endmodule

// File: rtl/acc_ctrl.sv
// Accumulator controller. Sequences an external registered accumulator
// through clear / accumulate / settle for a job of len operands, tracks
// modulo wrap, and presents the final sum with a one-cycle done pulse.
module acc_ctrl
    import acc_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    input  logic              op_valid,
    input  logic [DATA_W-1:0] op_data,
    output logic              op_ready,
    output logic [DATA_W-1:0] acc_in,
    output logic              acc_clr,
    output logic              acc_ce,
    input  logic [DATA_W-1:0] acc_out,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [LEN_W-1:0]   len_r;
    logic               ovf_acc_r;
    logic [DATA_W-1:0]  result_r;
    logic               ovf_r;
    logic               start_acc_s;
    logic               xfer_s;
    logic               tc_s;
    logic               carry_s;

    assign start_acc_s = (state_r == ST_IDLE) && start;
    assign xfer_s      = (state_r == ST_ACCUM) && op_valid;
    // Unsigned wrap detection on the DATA_W+1-bit sum of current total and operand.
    assign carry_s     = (({1'b0, acc_out} + {1'b0, op_data}) >= {1'b1, {DATA_W{1'b0}}});

    acc_ctrl_cnt #(
        .LEN_W (LEN_W)
    ) u_cnt (
        .pclk    (pclk),
        .reset_n (reset_n),
        .clr     (start_acc_s),
        .inc     (xfer_s),
        .len     (len_r),
        .tc      (tc_s)
    );

    // State register.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; abort outside IDLE overrides every other transition.
    always_comb begin
        state_nxt_s = state_r;
        if ((state_r != ST_IDLE) && abort) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt_s = ST_CLEAR;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    if (len_r == '0) begin
                        state_nxt_s = ST_SETTLE;
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (xfer_s && tc_s) begin
                        state_nxt_s = ST_SETTLE;
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end
                ST_SETTLE: state_nxt_s = ST_DONE;
                ST_DONE:   state_nxt_s = ST_IDLE;
                default:   state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Output decode; acc_in/acc_ce follow the handshake in the same cycle.
    always_comb begin
        op_ready = 1'b0;
        acc_clr  = 1'b0;
        acc_ce   = 1'b0;
        acc_in   = '0;
        busy     = (state_r != ST_IDLE);
        done     = (state_r == ST_DONE);
        case (state_r)
            ST_CLEAR: acc_clr = 1'b1;
            ST_ACCUM: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    acc_ce = 1'b1;
                    acc_in = op_data;
                end else begin
                    acc_ce = 1'b0;
                    acc_in = '0;
                end
            end
            default: begin
                op_ready = 1'b0;
                acc_clr  = 1'b0;
            end
        endcase
    end

    // Job length capture when a new job is accepted.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            len_r <= '0;
        end else if (start_acc_s) begin
            len_r <= len;
        end else begin
            len_r <= len_r;
        end
    end

    // Sticky wrap flag for the job in progress.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_acc_r <= 1'b0;
        end else if (start_acc_s) begin
            ovf_acc_r <= 1'b0;
        end else if (xfer_s && carry_s) begin
            ovf_acc_r <= 1'b1;
        end else begin
            ovf_acc_r <= ovf_acc_r;
        end
    end

    // Result/ovf capture on entry to DONE so they are valid alongside done;
    // an abort during SETTLE leaves the previous job's values in place.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            result_r <= '0;
            ovf_r    <= 1'b0;
        end else if ((state_r == ST_SETTLE) && !abort) begin
            result_r <= acc_out;
            ovf_r    <= ovf_acc_r;
        end else begin
            result_r <= result_r;
            ovf_r    <= ovf_r;
        end
    end

    assign result = result_r;
    assign ovf    = ovf_r;

endmodule
